// File: rtl/hyperbus_arbiter.sv
// hyperbus_arbiter
//   Round-robin arbiter and single-transaction sequencer in front of a
//   HyperBus controller core. One 16-bit request is in flight at a time.
//   The winner's fields are latched into the hb_* holding registers. The
//   request is then issued as a one-cycle wrq/rrq pulse. The sequencer waits
//   for the core's hb_valid, or gives up after TIMEOUT cycles, and returns the
//   result to the granted port.
//
// Ports
//   clk, rstn            : clock, synchronous active-low reset
//   req_valid/req_ready  : per-port request handshake (ready is a 1-cycle pulse)
//   req_we/req_reg       : per-port write / register-space flags
//   req_adr/dat/mask     : packed per-port address (32), data (16), mask (4)
//   rsp_valid            : per-port 1-cycle completion pulse
//   rsp_dat/rsp_err      : shared response data / timeout flag (held)
//   busy                 : sequencer not idle
//   hb_ready/hb_valid    : core idle / core completion pulse
//   hb_dat_i             : core read data
//   hb_wrq/hb_rrq        : write / read request pulses to the core
//   hb_adr/dat_o/mask/reg: held transaction fields to the core
module hyperbus_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ-1:0]   req_reg,
  input  logic [NREQ*32-1:0] req_adr,
  input  logic [NREQ*16-1:0] req_dat,
  input  logic [NREQ*4-1:0] req_mask,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [15:0]       rsp_dat,
  output logic              rsp_err,
  output logic              busy,
  input  logic              hb_ready,
  input  logic              hb_valid,
  input  logic [15:0]       hb_dat_i,
  output logic              hb_wrq,
  output logic              hb_rrq,
  output logic [31:0]       hb_adr,
  output logic [15:0]       hb_dat_o,
  output logic [3:0]        hb_mask,
  output logic              hb_reg
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, last_grant_reg;
  logic [GW-1:0]   pick;
  logic            pick_found;
  logic            accept;
  logic            we_reg;
  logic [TW-1:0]   timer_reg;
  int              cand;

  // Round-robin search: first valid port strictly after the last winner,
  // wrapping, so the last winner itself has the lowest priority.
  always_comb begin
    pick       = last_grant_reg;
    pick_found = 1'b0;
    cand       = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = int'(last_grant_reg) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!pick_found && req_valid[cand[GW-1:0]]) begin
        pick_found = 1'b1;
        pick       = cand[GW-1:0];
      end
    end
  end

  // Gated by rstn so a requester never sees an acceptance that the reset
  // edge is about to discard.
  assign accept = rstn && (state_reg == IDLE) && hb_ready && pick_found;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_port
      assign req_ready[gi] = accept && (pick == GW'(gi));
      assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == GW'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    hb_wrq     = 1'b0;
    hb_rrq     = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE:  if (accept) state_next = ISSUE;
      ISSUE: begin
        hb_wrq     = we_reg;
        hb_rrq     = !we_reg;
        state_next = WAIT;
      end
      WAIT:  if (hb_valid || (timer_reg == TIMER_LAST)) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NREQ - 1);
      timer_reg      <= '0;
      we_reg         <= 1'b0;
      hb_adr         <= '0;
      hb_dat_o       <= '0;
      hb_mask        <= '0;
      hb_reg         <= 1'b0;
      rsp_dat        <= '0;
      rsp_err        <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            grant_reg <= pick;
            we_reg    <= req_we[pick];
            hb_reg    <= req_reg[pick];
            hb_adr    <= req_adr[pick*32 +: 32];
            hb_dat_o  <= req_dat[pick*16 +: 16];
            hb_mask   <= req_mask[pick*4 +: 4];
          end
        end
        ISSUE: timer_reg <= '0;
        WAIT: begin
          timer_reg <= timer_reg + TW'(1);
          // A completion in the final timer cycle still counts as success.
          if (hb_valid) begin
            rsp_dat <= hb_dat_i;
            rsp_err <= 1'b0;
          end else if (timer_reg == TIMER_LAST) begin
            rsp_dat <= '0;
            rsp_err <= 1'b1;
          end
        end
        RESP: last_grant_reg <= grant_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hyperbus_arbiter.md
Name: hyperbus_arbiter

Overview:
- Round-robin arbiter and transaction sequencer placed in front of the hyperbus controller core.
- Shares one HyperBus device between NREQ requesters.
- Accepts one single-word (16-bit) request at a time and issues it to the core as a one-cycle wrq/rrq pulse.
- Waits for core completion, with a timeout watchdog, and routes the response back to the granted requester.

Parameters:
NREQ, 2, number of requester ports (2..8)
TIMEOUT, 1024, cycles to wait for hb_valid after issue before aborting with error (>=4)

Ports:
clk  input  1  system clock, same clock as the hyperbus core clk
rstn  input  1  synchronous active-low reset
req_valid  input  NREQ  per-port request present
req_ready  output  NREQ  one-cycle pulse: request on that port accepted
req_we  input  NREQ  1 = write, 0 = read
req_reg  input  NREQ  1 = register space, 0 = memory
req_adr  input  NREQ*32  packed addresses, port i at [32i+31:32i]
req_dat  input  NREQ*16  packed write data
req_mask  input  NREQ*4  packed byte masks
rsp_valid  output  NREQ  one-cycle completion pulse to the granted port
rsp_dat  output  16  read data, shared, valid with rsp_valid
rsp_err  output  1  timeout flag, valid with rsp_valid
busy  output  1  high in any state other than IDLE
hb_ready  input  1  core idle and able to accept
hb_valid  input  1  core one-cycle completion pulse, read or write
hb_dat_i  input  16  core read data (core dat_o)
hb_wrq  output  1  write request pulse to core
hb_rrq  output  1  read request pulse to core
hb_adr  output  32  to core adr_i
hb_dat_o  output  16  to core dat_i
hb_mask  output  4  to core mask_i
hb_reg  output  1  to core reg_space_i

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE; all outputs 0; hb_adr/hb_dat_o/hb_mask/hb_reg = 0.
  - last_grant = NREQ-1, so port 0 has first priority; timer = 0.
  - Reset mid-transaction abandons it silently: no rsp_valid, and no wrq/rrq in the next cycle.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If hb_ready=1 and any req_valid: select g = first set bit of req_valid, searching from (last_grant+1) mod NREQ upward with wrap.
  - Register req_we/req_reg/req_adr/req_dat/req_mask of port g into hb_* holding registers.
  - Pulse req_ready[g] this cycle, then go to ISSUE.
  - With hb_ready=0, no grant is made and req_ready stays 0.
- ISSUE: exactly one cycle.
  - hb_wrq=we or hb_rrq=!we is high for this cycle only.
  - timer cleared; go to WAIT.
- WAIT:
  - hb_* address, data, mask and reg outputs are held stable.
  - timer increments each cycle.
  - On hb_valid=1: capture hb_dat_i into rsp_dat (write: capture anyway), err=0, go to RESP.
  - Else if timer==TIMEOUT-1: rsp_dat=0, err=1, go to RESP.
  - hb_valid and timeout in the same cycle: hb_valid wins, err=0.
- RESP:
  - rsp_valid[g]=1 and rsp_err=err for one cycle.
  - last_grant=g; go to IDLE.
- hb_valid outside WAIT is ignored.
- rsp_dat and rsp_err hold their value until the next RESP.
- Latency:
  - accept (cycle T) -> wrq/rrq at T+1.
  - hb_valid at T+1+k (k>=1) -> rsp_valid at T+2+k.
  - Next accept is no earlier than T+3+k, so there are at most one outstanding transaction and one cycle gap.
- Requester rule: a requester holds req_valid and its fields stable until req_ready. Deasserting earlier is allowed; that request is simply not granted.
- Single-requester throughput is unaffected by round-robin; the same port may be regranted immediately if it is the only one valid.

Test Plan:
1. Port 0 read, adr=0x0000_0100, core returns 0xBEEF with hb_valid 5 cycles after rrq -> req_ready[0] at T, hb_rrq at T+1 only, rsp_valid[0] at T+7 with rsp_dat=0xBEEF, rsp_err=0.
2. Ports 0 and 1 both valid from reset, continuously -> grants go 0,1,0,1; each hb_adr matches the granted port's address; no double pulses on wrq/rrq.
3. Port 1 write, dat=0x1234, mask=4'b0011, reg=1 -> hb_wrq one pulse; hb_dat_o=0x1234, hb_mask=0011, hb_reg=1 held until hb_valid; rsp_valid[1] one cycle after hb_valid.
4. TIMEOUT=16, core never asserts hb_valid -> rsp_valid[0] with rsp_err=1 and rsp_dat=0 exactly 17 cycles after the rrq pulse; the next request proceeds normally.
5. hb_ready=0 while req_valid[0]=1 for 10 cycles -> req_ready stays 0 and busy=0; grant occurs in the first cycle hb_ready=1.
6. rstn=0 for one cycle during WAIT -> all outputs 0 next cycle, no rsp_valid; a late hb_valid is ignored; a subsequent port-0 request completes normally.
